// File: rtl/core_pkg.sv
// Shared constants for the in-order RISC-V core: write-back source codes,
// load-size codes and default datapath widths.
package core_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] LS_B = 2'd0;
    localparam logic [1:0] LS_H = 2'd1;
    localparam logic [1:0] LS_W = 2'd2;

    // Access is misaligned when it does not sit on its natural boundary,
    // and the reserved size code is always treated as misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            LS_B:    mis = 1'b0;
            LS_H:    mis = addr_lo[0];
            LS_W:    mis = (addr_lo != 2'd0);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Sub-word load alignment: picks the byte/half/word lane from the raw
// memory word and sign- or zero-extends it to XLEN.
module load_align
    import core_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] mem_data,
    input  logic [1:0]      addr_lo,
    input  logic [1:0]      size,
    input  logic            zero_ext,
    output logic [XLEN-1:0] data,
    output logic            misaligned
);

    logic [31:0] word_field;
    logic [15:0] half_field;
    logic [7:0]  byte_field;
    logic [XLEN-1:0] ext_data;

    // Lanes are always indexed within the low 32 bits, also for XLEN=64.
    assign word_field = mem_data[31:0];
    assign byte_field = word_field[{addr_lo, 3'b000} +: 8];
    assign half_field = word_field[{addr_lo[1], 4'b0000} +: 16];

    function automatic logic [XLEN-1:0] ext_byte(input logic [7:0] v, input logic zext);
        logic signed [7:0] sv;
        sv = v;
        if (zext) return XLEN'(v);
        return XLEN'(sv);
    endfunction

    function automatic logic [XLEN-1:0] ext_half(input logic [15:0] v, input logic zext);
        logic signed [15:0] sv;
        sv = v;
        if (zext) return XLEN'(v);
        return XLEN'(sv);
    endfunction

    function automatic logic [XLEN-1:0] ext_word(input logic [31:0] v, input logic zext);
        logic signed [31:0] sv;
        sv = v;
        if (zext) return XLEN'(v);
        return XLEN'(sv);
    endfunction

    always_comb begin
        ext_data = '0;
        case (size)
            LS_B:    ext_data = ext_byte(byte_field, zero_ext);
            LS_H:    ext_data = ext_half(half_field, zero_ext);
            LS_W:    ext_data = ext_word(word_field, zero_ext);
            default: ext_data = '0;
        endcase
    end

    assign misaligned = is_misaligned(size, addr_lo);
    assign data       = misaligned ? '0 : ext_data;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: write-back source select, load alignment,
// stall/flush handling, misaligned-load flag and retired-instruction counter.
module mem_wb_stage
    import core_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic              regwrite_i,
    input  logic [1:0]        wb_sel_i,
    input  logic [1:0]        load_size_i,
    input  logic              load_unsigned_i,
    input  logic [1:0]        addr_lo_i,
    input  logic [XLEN-1:0]   mem_data_i,
    input  logic [XLEN-1:0]   alu_result_i,
    input  logic [XLEN-1:0]   pc_plus4_i,
    input  logic [REG_AW-1:0] rd_i,
    output logic              valid_o,
    output logic              regwrite_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic [REG_AW-1:0] rd_o,
    output logic              misalign_o,
    output logic [CNT_W-1:0]  retired_o
);

    logic [XLEN-1:0] load_data;
    logic            load_misaligned;

    load_align #(
        .XLEN(XLEN)
    ) u_load_align (
        .mem_data  (mem_data_i),
        .addr_lo   (addr_lo_i),
        .size      (load_size_i),
        .zero_ext  (load_unsigned_i),
        .data      (load_data),
        .misaligned(load_misaligned)
    );

    logic            misaligned_load;
    logic            regwrite_p0;
    logic            misalign_p0;
    logic [XLEN-1:0] wdata_p0;

    // Stage p0: combinational write-back value and qualifiers
    always_comb begin
        misaligned_load = (wb_sel_i == WB_MEM) & load_misaligned;
        case (wb_sel_i)
            WB_ALU:  wdata_p0 = alu_result_i;
            WB_MEM:  wdata_p0 = load_data;
            WB_PC4:  wdata_p0 = pc_plus4_i;
            default: wdata_p0 = '0;
        endcase
        misalign_p0 = valid_i & misaligned_load;
        regwrite_p0 = valid_i & regwrite_i & (rd_i != '0) & ~misaligned_load;
    end

    logic              vld_p1;
    logic              regwrite_p1;
    logic              misalign_p1;
    logic [XLEN-1:0]   wdata_p1;
    logic [REG_AW-1:0] rd_p1;
    logic [CNT_W-1:0]  retired_p1;

    // Stage p1: WB register; flush beats stall, stall freezes everything
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            vld_p1      <= 1'b0;
            regwrite_p1 <= 1'b0;
            misalign_p1 <= 1'b0;
            wdata_p1    <= '0;
            rd_p1       <= '0;
            retired_p1  <= '0;
        end else if (flush_i) begin
            vld_p1      <= 1'b0;
            regwrite_p1 <= 1'b0;
            misalign_p1 <= 1'b0;
            wdata_p1    <= '0;
            rd_p1       <= '0;
        end else if (!stall_i) begin
            vld_p1      <= valid_i;
            regwrite_p1 <= regwrite_p0;
            misalign_p1 <= misalign_p0;
            wdata_p1    <= wdata_p0;
            rd_p1       <= rd_i;
            if (valid_i) begin
                retired_p1 <= retired_p1 + CNT_W'(1);
            end
        end
    end

    assign valid_o    = vld_p1;
    assign regwrite_o = regwrite_p1;
    assign misalign_o = misalign_p1;
    assign wdata_o    = wdata_p1;
    assign rd_o       = rd_p1;
    assign retired_o  = retired_p1;

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Parametrised MEM/WB pipeline register for the in-order RISC-V core. It sits between the data-memory stage and the register-file write port. It does the following:
- selects the write-back source (ALU, load, PC+4);
- aligns and sign/zero-extends sub-word loads;
- supports stall and flush;
- flags misaligned loads;
- keeps a retired-instruction counter.
All outputs are registered on the rising clock edge only.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
REG_AW, 5, register-address width.
CNT_W, 32, retired-instruction counter width.

Ports:
clk  in  1  clock; all state updates on posedge.
rst_n  in  1  reset, asynchronous, active-high.
stall_i  in  1  hold all stage state.
flush_i  in  1  squash the incoming instruction.
valid_i  in  1  incoming MEM-stage slot holds a real instruction.
regwrite_i  in  1  instruction writes rd.
wb_sel_i  in  2  write-back source: 0 ALU, 1 MEM, 2 PC+4, 3 reserved.
load_size_i  in  2  0 byte, 1 half, 2 word; 3 reserved.
load_unsigned_i  in  1  1 = zero-extend, 0 = sign-extend.
addr_lo_i  in  2  low two bits of the load address.
mem_data_i  in  XLEN  raw aligned word read from data memory.
alu_result_i  in  XLEN  ALU result.
pc_plus4_i  in  XLEN  link value.
rd_i  in  REG_AW  destination register.
valid_o  out  1  WB slot holds a real instruction.
regwrite_o  out  1  register-file write enable.
wdata_o  out  XLEN  write-back data.
rd_o  out  REG_AW  write-back address.
misalign_o  out  1  WB instruction was a misaligned load.
retired_o  out  CNT_W  count of instructions captured into WB.

Behaviour:
- Reset (async, rst_n=1): every output is 0, including retired_o. Reset takes effect immediately and overrides any operation in progress. The first capture occurs on the first posedge after rst_n falls.
- Latency: 1 cycle. Values present at posedge N appear on the outputs after posedge N.
- Per-posedge priority: flush_i > stall_i > normal capture.
- Flush: valid_o, regwrite_o, misalign_o, wdata_o and rd_o all become 0. retired_o holds. Flush wins over a simultaneous stall.
- Stall (no flush): all outputs hold, including retired_o.
- Normal capture:
  - valid_o <= valid_i.
  - rd_o <= rd_i.
  - wdata_o <= the selected value (see below).
  - misalign_o <= valid_i & (wb_sel_i==1) & misaligned.
  - regwrite_o <= valid_i & regwrite_i & (rd_i != 0) & ~misaligned_load.
- Retired counter: retired_o increments by 1 on a normal capture with valid_i=1. It wraps from 2^CNT_W-1 to 0. A misaligned load still counts as retired.
- Source select: wb_sel 0 gives alu_result_i, 1 gives the load value, 2 gives pc_plus4_i, 3 gives 0.
- Load alignment (XLEN=32 lane indexing):
  - Byte: take mem_data_i[8*addr_lo_i +: 8].
  - Half: take mem_data_i[16*addr_lo_i[1] +: 16].
  - Word: take mem_data_i[31:0].
  - Extend the selected field to XLEN by sign (load_unsigned_i=0) or zero (load_unsigned_i=1).
  - Word with XLEN=64: zero- or sign-extend the 32-bit value.
- Misaligned cases:
  - half with addr_lo_i[0]=1;
  - word with addr_lo_i != 0;
  - load_size_i == 3.
  - In every misaligned case wdata_o is 0 and regwrite_o is 0.
- When wb_sel != 1, load_size_i, load_unsigned_i and addr_lo_i are ignored.
- x0 rule: regwrite_o is never 1 with rd_o=0.

Decomposition:
- Shared package core_pkg holds:
  - constants WB_ALU=0, WB_MEM=1, WB_PC4=2;
  - constants LS_B=0, LS_H=1, LS_W=2;
  - default XLEN and REG_AW.
- One combinational sub-module, load_align, takes mem_data, addr_lo, size and unsigned. It outputs the extended data and the misaligned flag. It is instantiated once.

Test Plan:
- Reset:
  - Assert rst_n mid-cycle with valid traffic -> all outputs 0 immediately, without waiting for a clock edge.
  - Release rst_n, then capture ALU op rd=5, alu=0x1234 -> next cycle regwrite_o=1, rd_o=5, wdata_o=0x00001234, retired_o=1.
- Signed byte load:
  - mem=0x80FF7F01, addr_lo=1 -> wdata_o=0x0000007F.
  - Same input with addr_lo=3, signed -> wdata_o=0xFFFFFF80.
  - Same input with addr_lo=3, unsigned -> wdata_o=0x00000080.
- Half loads:
  - mem=0x8001ABCD, addr_lo=2, signed -> wdata_o=0xFFFF8001.
  - Half with addr_lo=1 -> misalign_o=1, regwrite_o=0, wdata_o=0, retired_o still increments.
- Stall and flush:
  - Stall 3 cycles while inputs change -> outputs and retired_o frozen.
  - stall_i=1 together with flush_i=1 -> valid_o=0, regwrite_o=0, rd_o=0, retired_o unchanged.
- x0 and link:
  - rd_i=0 with regwrite_i=1 -> regwrite_o=0.
  - wb_sel=2, pc_plus4=0x104, rd=1 -> wdata_o=0x104, regwrite_o=1.
- Counter wrap: CNT_W=4, 17 valid captures -> retired_o sequence reaches 15, then 0, then 1.
